// File: rtl/router_olck_pkg.sv
// Shared definitions for the multi-channel output-link elastic pipeline.
package router_olck_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DEPTH  = 2;

  // Occupancy ranges over 0..2*DEPTH (main + skid per stage), so size for 2*DEPTH+1 values.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

  // Fill state of one elastic stage: nothing held, main only, main and skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/router_olck_skid_stage.sv
// One elastic register stage: registered main slot plus a skid slot.
// Ready is a function of the stage's own state only, so no combinational
// path exists from out_ready to in_ready or from in_* to out_*.
module router_olck_skid_stage
  import router_olck_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  stage_state_e     state_q;
  stage_state_e     state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic             load_skid;
  logic             skid_to_main;

  // Ready drops while the skid slot is occupied, and is forced low during reset and flush.
  assign in_ready  = (state_q != FULL) && !flush && !reset;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Next fill state and which data slot loads this cycle.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = MAIN;
            load_main = 1'b1;
          end
        end
        MAIN: begin
          if (out_fire && in_fire) begin
            load_main = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d      = MAIN;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Fill-state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Data slots: cleared by reset so out_data reads zero; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= in_data;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  // The state register must only ever hold a legal encoding.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (state_q inside {EMPTY, MAIN, FULL});
    end
  end

endmodule

// File: rtl/router_olck_pipe.sv
// NUM_CH independent channels, each a chain of DEPTH skid stages, with a
// registered per-channel occupancy count of flits held in the chain.
module router_olck_pipe
  import router_olck_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_CH-1:0]                  in_valid,
  input  logic [NUM_CH*WIDTH-1:0]            in_data,
  output logic [NUM_CH-1:0]                  in_ready,
  output logic [NUM_CH-1:0]                  out_valid,
  output logic [NUM_CH*WIDTH-1:0]            out_data,
  input  logic [NUM_CH-1:0]                  out_ready,
  output logic [NUM_CH*occ_width(DEPTH)-1:0] occupancy
);

  localparam int             OCC_W   = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(2 * DEPTH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DEPTH:0]             vld;
    logic [DEPTH:0]             rdy;
    logic [(DEPTH+1)*WIDTH-1:0] dat;
    logic                       in_fire;
    logic                       out_fire;
    logic [OCC_W-1:0]           occ_q;

    assign vld[0]                        = in_valid[c];
    assign dat[0 +: WIDTH]               = in_data[c*WIDTH +: WIDTH];
    assign in_ready[c]                   = rdy[0];
    assign out_valid[c]                  = vld[DEPTH];
    assign out_data[c*WIDTH +: WIDTH]    = dat[DEPTH*WIDTH +: WIDTH];
    assign rdy[DEPTH]                    = out_ready[c];

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      router_olck_skid_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (vld[s]),
        .in_data  (dat[s*WIDTH +: WIDTH]),
        .in_ready (rdy[s]),
        .out_valid(vld[s+1]),
        .out_data (dat[(s+1)*WIDTH +: WIDTH]),
        .out_ready(rdy[s+1])
      );
    end

    assign in_fire  = in_valid[c] && rdy[0];
    assign out_fire = vld[DEPTH] && out_ready[c];

    // Occupancy follows the boundary handshakes; flush and reset empty the channel.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        occ_q <= '0;
      end else begin
        case ({in_fire, out_fire})
          2'b10:   occ_q <= occ_q + 1'b1;
          2'b01:   occ_q <= occ_q - 1'b1;
          default: occ_q <= occ_q;
        endcase
      end
    end

    assign occupancy[c*OCC_W +: OCC_W] = occ_q;

    // The count must stay inside 0..2*DEPTH without wrapping.
    always_ff @(posedge clk) begin
      if (!reset && !flush) begin
        assert (!(in_fire && !out_fire && occ_q == OCC_MAX));
        assert (!(out_fire && !in_fire && occ_q == '0));
      end
    end
  end

endmodule
